// File: rtl/ccff_loader_pkg.sv
// Shared types and defaults for the configuration-chain bitstream loader.
package ccff_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE,
        ERR
    } state_t;

    localparam int DEF_WORD_W      = 8;
    localparam int DEF_CHAIN_LEN   = 20;
    localparam int DEF_TIMEOUT_CYC = 1024;

    // Width needed to hold every count from 0 up to and including chain_len.
    function automatic int cnt_width(input int chain_len);
        return $clog2(chain_len + 1);
    endfunction

endpackage

// File: rtl/ccff_word_piso.sv
// Parallel-in/serial-out word buffer, LSB first; bit_out holds its last value once drained.
module ccff_word_piso #(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [WORD_W-1:0] data,
    input  logic              shift,
    input  logic              clear,
    output logic              bit_out,
    output logic              empty,
    output logic              last_bit
);
    localparam int REM_W = $clog2(WORD_W + 1);

    logic [WORD_W-1:0] sreg_reg;
    logic [REM_W-1:0]  rem_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sreg_reg <= '0;
            rem_reg  <= '0;
        end else if (clear) begin
            rem_reg <= '0;
        end else if (load) begin
            sreg_reg <= data;
            rem_reg  <= REM_W'(WORD_W);
        end else if (shift && (rem_reg != '0)) begin
            rem_reg <= rem_reg - REM_W'(1);
            // The final bit is not shifted out so the serial line keeps its value while starved.
            if (rem_reg != REM_W'(1)) begin
                sreg_reg <= sreg_reg >> 1;
            end
        end
    end

    assign bit_out  = sreg_reg[0];
    assign empty    = (rem_reg == '0);
    assign last_bit = (rem_reg == REM_W'(1));

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Serialises bitstream words into the I/O tile config chain and releases pad isolation after a full load.
// Optional starvation timeout is built when CCFF_LOADER_TIMEOUT_EN is defined.
module ccff_bitstream_loader
    import ccff_loader_pkg::*;
#(
    parameter int WORD_W      = DEF_WORD_W,
    parameter int CHAIN_LEN   = DEF_CHAIN_LEN,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                               prog_clk,
    input  logic                               pReset_N,
    input  logic                               start,
    input  logic [WORD_W-1:0]                  bs_data,
    input  logic                               bs_valid,
    output logic                               bs_ready,
    output logic                               ccff_head,
    output logic                               ccff_shift_en,
    input  logic                               ccff_tail,
    output logic                               IO_ISOL_N,
    output logic                               busy,
    output logic                               done,
    output logic [cnt_width(CHAIN_LEN)-1:0]    bit_cnt,
    output logic                               err
);
    localparam int               CNT_W       = cnt_width(CHAIN_LEN);
    localparam logic [CNT_W-1:0] CHAIN_LEN_C = CNT_W'(CHAIN_LEN);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] bit_cnt_reg, cnt_plus;
    logic             shift_en_reg, iso_reg, busy_reg, done_reg;
    logic             piso_load, piso_shift, piso_clear;
    logic             piso_bit, piso_empty, piso_last;
    logic             start_load, cnt_inc, chain_full, timeout_hit;
    logic             unused_ok;

    ccff_word_piso #(.WORD_W(WORD_W)) u_piso (
        .clk      (prog_clk),
        .rst_n    (pReset_N),
        .load     (piso_load),
        .data     (bs_data),
        .shift    (piso_shift),
        .clear    (piso_clear),
        .bit_out  (piso_bit),
        .empty    (piso_empty),
        .last_bit (piso_last)
    );

    // bit_cnt counts bits already taken by the chain, so cnt_plus includes the bit on ccff_head.
    assign cnt_plus   = bit_cnt_reg + CNT_W'(1);
    assign chain_full = (cnt_plus == CHAIN_LEN_C);

    always_comb begin
        state_next = state_reg;
        bs_ready   = 1'b0;
        piso_load  = 1'b0;
        piso_shift = 1'b0;
        piso_clear = 1'b0;
        start_load = 1'b0;
        cnt_inc    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = LOAD;
                    start_load = 1'b1;
                end
            end
            LOAD: begin
                bs_ready = piso_empty;
                if (bs_valid && bs_ready) begin
                    piso_load  = 1'b1;
                    state_next = SHIFT;
                end else if (timeout_hit) begin
                    state_next = ERR;
                end
            end
            SHIFT: begin
                cnt_inc = 1'b1;
                if (chain_full) begin
                    piso_clear = 1'b1;
                    state_next = DONE;
                end else if (piso_last) begin
                    bs_ready = 1'b1;
                    if (bs_valid) begin
                        piso_load = 1'b1;
                    end else begin
                        piso_shift = 1'b1;
                        state_next = LOAD;
                    end
                end else begin
                    piso_shift = 1'b1;
                end
            end
            DONE: state_next = IDLE;
            ERR: begin
                if (start) begin
                    state_next = LOAD;
                    start_load = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge prog_clk) begin
        if (!pReset_N) begin
            state_reg    <= IDLE;
            bit_cnt_reg  <= '0;
            shift_en_reg <= 1'b0;
            iso_reg      <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            shift_en_reg <= (state_next == SHIFT);
            busy_reg     <= (state_next == LOAD) || (state_next == SHIFT);
            done_reg     <= (state_next == DONE);
            if (start_load) begin
                bit_cnt_reg <= '0;
                iso_reg     <= 1'b0;
            end else begin
                if (cnt_inc) begin
                    bit_cnt_reg <= cnt_plus;
                end
                if (state_next == DONE) begin
                    iso_reg <= 1'b1;
                end
            end
        end
    end

`ifdef CCFF_LOADER_TIMEOUT_EN
    localparam int ST_W = $clog2(TIMEOUT_CYC + 1);

    logic [ST_W-1:0] starve_reg;
    logic            err_reg;

    assign timeout_hit = (state_reg == LOAD) && !bs_valid && (starve_reg == ST_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge prog_clk) begin
        if (!pReset_N) begin
            starve_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            if ((state_reg == LOAD) && !bs_valid) begin
                starve_reg <= starve_reg + ST_W'(1);
            end else begin
                starve_reg <= '0;
            end
            if (start_load) begin
                err_reg <= 1'b0;
            end else if (state_next == ERR) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign err = err_reg;
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    // The chain tail is observed only; the base block has no use for it.
    assign unused_ok = ccff_tail ^ (TIMEOUT_CYC == 0);

    assign ccff_head     = piso_bit;
    assign ccff_shift_en = shift_en_reg;
    assign IO_ISOL_N     = iso_reg;
    assign busy          = busy_reg;
    assign done          = done_reg;
    assign bit_cnt       = bit_cnt_reg;

endmodule

// File: doc/ccff_bitstream_loader.md
Name: ccff_bitstream_loader

Overview:
- Sits directly upstream of the I/O tiles' configuration chain and drives `ccff_head`.
- Accepts bitstream words over a valid/ready handshake and serialises them LSB-first into the chain. It emits a per-bit shift enable and counts bits up to the chain length.
- Drives `IO_ISOL_N` so the I/O pads stay isolated until a full chain load completes.

Parameters:
- WORD_W, 8, width of a bitstream word on the input bus
- CHAIN_LEN, 20, total configuration bits in the downstream chain; range 1..2^16-1
- TIMEOUT_CYC, 1024, starvation limit in cycles; used only with the optional feature

Ports:
- prog_clk  input  1  programming clock; all logic on its rising edge
- pReset_N  input  1  synchronous active-low reset
- start  input  1  single-cycle request to begin a chain load
- bs_data  input  WORD_W  bitstream word; bit 0 is shifted first
- bs_valid  input  1  bs_data is valid
- bs_ready  output  1  loader accepts bs_data this cycle
- ccff_head  output  1  serial configuration bit into the chain
- ccff_shift_en  output  1  chain advances this cycle (drives the external chain clock gate)
- ccff_tail  input  1  chain tail; monitored only, no functional effect in the base block
- IO_ISOL_N  output  1  0 = pads isolated, 1 = pads released
- busy  output  1  a load is in progress
- done  output  1  one-cycle pulse when a load completes
- bit_cnt  output  CNT_W  bits shifted so far; CNT_W = $clog2(CHAIN_LEN+1)
- err  output  1  sticky timeout flag; tied to 0 when the optional feature is off

Behaviour:
- Clock and reset: one clock, `prog_clk`; reset is synchronous and active-low (`pReset_N`). All state is sampled on the rising edge of `prog_clk`.
- Reset values: state IDLE; bs_ready=0, ccff_head=0, ccff_shift_en=0, IO_ISOL_N=0, busy=0, done=0, bit_cnt=0, err=0. Shift buffer empty.
- Reset mid-load: the load is abandoned immediately. Pads stay isolated and there is no done pulse.
- IDLE:
  - bs_ready=0; bs_valid is ignored.
  - start=1 moves to LOAD. On that edge: bit_cnt cleared, IO_ISOL_N forced to 0, err cleared, busy set.
- LOAD (buffer empty): bs_ready=1. A transfer (bs_valid && bs_ready) latches bs_data and moves to SHIFT.
- SHIFT:
  - Each cycle registers the next buffer bit (bit 0 first) onto ccff_head with ccff_shift_en=1, and increments bit_cnt.
  - ccff_head and ccff_shift_en are registered together. The first bit of an accepted word appears on the cycle after acceptance.
  - Back-to-back words: bs_ready=1 during the cycle that outputs the word's last bit, provided bit_cnt+1 < CHAIN_LEN. A word accepted then starts on the next cycle with no bubble.
  - Starvation: if no word is waiting after the last bit, go to LOAD. ccff_shift_en=0 and ccff_head holds its last value until the next transfer.
- Completion:
  - When bit_cnt reaches CHAIN_LEN, the remaining bits of the current word are discarded and bs_ready drops.
  - Next cycle is DONE: done=1 for one cycle, IO_ISOL_N=1, busy=0, ccff_shift_en=0. Then return to IDLE.
  - IO_ISOL_N stays 1 until the next start or reset.
- start while busy is ignored.
- start in the same cycle as done is ignored; start must be asserted in IDLE.
- bit_cnt saturates at CHAIN_LEN and holds after DONE until the next start.
- When CHAIN_LEN is not a multiple of WORD_W, the upper bits of the final word are don't-care.

Optional Feature:
- Macro: CCFF_LOADER_TIMEOUT_EN.
- Defined:
  - A starvation counter runs only in LOAD while busy and the chain is not yet complete, and clears on every transfer.
  - On reaching TIMEOUT_CYC consecutive cycles without a transfer: move to ERR, set err=1, busy=0, bs_ready=0, no done pulse, IO_ISOL_N stays 0.
  - ERR exits to LOAD only on start; err clears on that start.
- Undefined: LOAD waits indefinitely; err is tied to 0; no counter logic is generated.

Decomposition:
- Package ccff_loader_pkg holds:
  - the state enum {IDLE, LOAD, SHIFT, DONE, ERR};
  - default parameter constants;
  - the CNT_W derivation function.
- One natural sub-module, ccff_word_piso. It is the WORD_W-bit parallel-in/serial-out buffer with:
  - load, shift, empty and last_bit signals;
  - no knowledge of chain length.
- The FSM, counters and isolation control stay in the top module.

Test Plan:
- Reset: hold pReset_N=0 for 2 cycles with bs_valid=1 and start=1 -> all outputs at reset values, IO_ISOL_N=0, no transfer.
- Nominal load, WORD_W=8, CHAIN_LEN=20: start, then words 0xA5, 0x3C, 0x0F back-to-back ->
  - ccff_head = 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1,1,1,1;
  - ccff_shift_en high for exactly 20 consecutive cycles;
  - exactly 3 transfers;
  - done high for one cycle immediately after the 20th bit, IO_ISOL_N=1 from that cycle, bit_cnt=20.
- Bubble: as above, but bs_valid withheld 5 cycles between words 1 and 2 -> ccff_shift_en low for exactly 5 cycles, ccff_head held, same 20-bit sequence and done.
- Ignored inputs: start pulsed at bit 7 -> no restart, bit_cnt continues. bs_valid=1 in IDLE -> bs_ready stays 0.
- Reset mid-load: pReset_N=0 for 1 cycle after 10 bits -> IDLE, bit_cnt=0, IO_ISOL_N=0, no done; a following start loads a full 20 bits.
- Timeout (macro defined, TIMEOUT_CYC=16): after word 1, stall 16 cycles -> err=1, busy=0, IO_ISOL_N=0; a new start clears err and restarts with bit_cnt=0.
